window_stream_packer: RTL and testbench

Parametrised successor to the window serializer. It accepts one wide window plus metadata per ready/valid handshake and emits it as a sequence of BUS_WIDTH beats. Each beat carries the metadata, a beat index and a `stream_last` flag; the final beat is zero-padded. A two-entry window buffer lets consecutive windows stream with no idle cycle between them. It sits between the window/descriptor stage and the downstream bus-width consumer.

---
 rtl/window_stream_packer_if.sv | 28 ++
 rtl/window_stream_packer.sv | 130 +++++++++++++
 tb/tb_window_stream_packer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_stream_packer_if.sv
// Handshake bundle between the window/descriptor stage, the packer and the
// bus-width beat consumer.
interface window_stream_packer_if #(
  parameter int unsigned WINDOW_WIDTH = 1152,
  parameter int unsigned BUS_WIDTH    = 128,
  parameter int unsigned META_WIDTH   = 4
);
  logic                    window_valid;
  logic [WINDOW_WIDTH-1:0] window;
  logic [META_WIDTH-1:0]   metadata;
  logic                    window_ready;
  logic                    stream_valid;
  logic                    stream_ready;
  logic [BUS_WIDTH-1:0]    stream;
  logic                    stream_last;

  // Packer side: consumes windows, produces beats.
  modport slave (
    input  window_valid, window, metadata, stream_ready,
    output window_ready, stream_valid, stream, stream_last
  );

  // Environment side: offers windows, consumes beats.
  modport master (
    output window_valid, window, metadata, stream_ready,
    input  window_ready, stream_valid, stream, stream_last
  );
endinterface

// File: rtl/window_stream_packer.sv
// Splits one wide window plus metadata into N bus beats of
// {metadata, beat_idx, payload}. A two-entry buffer (active + pending) lets
// consecutive windows stream back to back without an idle cycle.
module window_stream_packer #(
  parameter int unsigned WINDOW_WIDTH = 1152,
  parameter int unsigned BUS_WIDTH    = 128,
  parameter int unsigned META_WIDTH   = 4,
  parameter int unsigned IDX_WIDTH    = 4
) (
  input logic                   clk,
  input logic                   rst,
  window_stream_packer_if.slave bus
);
  localparam int DataW     = int'(BUS_WIDTH) - int'(META_WIDTH) - int'(IDX_WIDTH);
  localparam int DataWSafe = (DataW < 1) ? 1 : DataW;
  localparam int NumBeats  = (int'(WINDOW_WIDTH) + DataWSafe - 1) / DataWSafe;
  localparam int Slots     = 1 << IDX_WIDTH;

  if (DataW < 1 || NumBeats > Slots) begin : g_bad_cfg
    $error("window_stream_packer: DATA_W < 1 or beat count exceeds beat-index range");
  end

  localparam logic [IDX_WIDTH-1:0] LastCnt = IDX_WIDTH'(NumBeats - 1);

  // Occupancy of the two-entry buffer: StOne = active only, StTwo = active + pending.
  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e                  state_q, state_d;
  logic [WINDOW_WIDTH-1:0] act_win_q, act_win_d, pend_win_q, pend_win_d;
  logic [META_WIDTH-1:0]   act_meta_q, act_meta_d, pend_meta_q, pend_meta_d;
  logic [IDX_WIDTH-1:0]    cnt_q, cnt_d;

  logic act_v, pend_v, is_last, accept, beat_fire, retire;

  assign act_v     = (state_q != StEmpty);
  assign pend_v    = (state_q == StTwo);
  assign is_last   = (cnt_q == LastCnt);
  assign accept    = bus.window_valid & ~pend_v;
  assign beat_fire = act_v & bus.stream_ready;
  assign retire    = beat_fire & is_last;

  // Next-state: route each accepted window to exactly one entry, advance beats.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_win_d   = act_win_q;
    act_meta_d  = act_meta_q;
    pend_win_d  = pend_win_q;
    pend_meta_d = pend_meta_q;

    if (beat_fire && !is_last) begin
      cnt_d = cnt_q + IDX_WIDTH'(1);
    end

    case (state_q)
      StEmpty: begin
        if (accept) begin
          act_win_d  = bus.window;
          act_meta_d = bus.metadata;
          cnt_d      = '0;
          state_d    = StOne;
        end
      end
      StOne: begin
        if (retire) begin
          cnt_d = '0;
          if (accept) begin
            // Retiring window hands the active slot straight to the new one.
            act_win_d  = bus.window;
            act_meta_d = bus.metadata;
          end else begin
            state_d = StEmpty;
          end
        end else if (accept) begin
          pend_win_d  = bus.window;
          pend_meta_d = bus.metadata;
          state_d     = StTwo;
        end
      end
      StTwo: begin
        if (retire) begin
          act_win_d  = pend_win_q;
          act_meta_d = pend_meta_q;
          cnt_d      = '0;
          state_d    = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // State and buffer registers; reset discards any partially sent window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      cnt_q       <= '0;
      act_win_q   <= '0;
      act_meta_q  <= '0;
      pend_win_q  <= '0;
      pend_meta_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_win_q   <= act_win_d;
      act_meta_q  <= act_meta_d;
      pend_win_q  <= pend_win_d;
      pend_meta_q <= pend_meta_d;
    end
  end

  // Zero-pad the active window out to a whole number of index slots so the
  // beat select is a plain array index and the last beat's upper bits are 0.
  logic [Slots*DataWSafe-1:0]          win_flat;
  logic [Slots-1:0][DataWSafe-1:0]     beats;
  logic [DataWSafe-1:0]                payload;

  // Padded view of the active window.
  always_comb begin
    win_flat                   = '0;
    win_flat[WINDOW_WIDTH-1:0] = act_win_q;
  end

  assign beats   = win_flat;
  assign payload = beats[cnt_q];

  assign bus.window_ready = ~pend_v;
  assign bus.stream_valid = act_v;
  assign bus.stream_last  = act_v & is_last;
  assign bus.stream       = act_v ? {act_meta_q, cnt_q, payload} : '0;
endmodule

// File: tb/tb_window_stream_packer.sv
// Bench for window_stream_packer: default configuration checked through an
// expected-beat queue and an independent monitor, plus a small variant
// configuration checked directly.
module tb_window_stream_packer;
  localparam int unsigned WW  = 1152;
  localparam int unsigned BW  = 128;
  localparam int unsigned MW  = 4;
  localparam int unsigned IW  = 4;
  localparam int          DW  = 120;
  localparam int          NB  = 10;
  localparam int unsigned VWW = 256;
  localparam int unsigned VBW = 64;
  localparam int unsigned VMW = 4;
  localparam int unsigned VIW = 3;
  localparam int          VDW = 57;
  localparam int          VNB = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  window_stream_packer_if #(.WINDOW_WIDTH(WW), .BUS_WIDTH(BW), .META_WIDTH(MW)) bus ();
  window_stream_packer_if #(.WINDOW_WIDTH(VWW), .BUS_WIDTH(VBW), .META_WIDTH(VMW)) vbus ();

  window_stream_packer #(
    .WINDOW_WIDTH(WW), .BUS_WIDTH(BW), .META_WIDTH(MW), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  window_stream_packer #(
    .WINDOW_WIDTH(VWW), .BUS_WIDTH(VBW), .META_WIDTH(VMW), .IDX_WIDTH(VIW)
  ) vdut (
    .clk(clk), .rst(rst), .bus(vbus)
  );

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [WW-1:0] mk_win(input int m, input int off);
    logic [WW-1:0] w;
    for (int i = 0; i < int'(WW); i++) w[i] = ((i + off) % m == 0);
    return w;
  endfunction

  function automatic logic [BW-1:0] exp_beat(input logic [WW-1:0] w, input logic [MW-1:0] m,
                                             input int k);
    logic [WW-1:0] sh;
    logic [IW-1:0] idx;
    sh  = w >> (k * DW);
    idx = k[IW-1:0];
    return {m, idx, sh[DW-1:0]};
  endfunction

  function automatic logic [VBW-1:0] vexp_beat(input logic [VWW-1:0] w, input logic [VMW-1:0] m,
                                               input int k);
    logic [VWW-1:0] sh;
    logic [VIW-1:0] idx;
    sh  = w >> (k * VDW);
    idx = k[VIW-1:0];
    return {m, idx, sh[VDW-1:0]};
  endfunction

  // Offer a window and queue the beats it must produce.
  task automatic present(input logic [WW-1:0] w, input logic [MW-1:0] m);
    exp_t e;
    bus.window_valid = 1'b1;
    bus.window       = w;
    bus.metadata     = m;
    for (int k = 0; k < NB; k++) begin
      e.data = exp_beat(w, m, k);
      e.last = (k == NB - 1);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: pops on every beat handshake, and checks hold-stability on stalls.
  initial begin : monitor
    logic [BW-1:0] prev_stream;
    logic          prev_last;
    logic          prev_stall;
    exp_t          e;
    prev_stall  = 1'b0;
    prev_stream = '0;
    prev_last   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_stream_stable", bus.stream, prev_stream);
          check("stall_valid_last_stable", BW'({bus.stream_valid, bus.stream_last}),
                BW'({1'b1, prev_last}));
        end
        if (bus.stream_valid && bus.stream_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%h required=none at %0t", bus.stream, $time);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", bus.stream, e.data);
            check("beat_last", BW'(bus.stream_last), BW'(e.last));
          end
        end
        prev_stall  = bus.stream_valid && !bus.stream_ready;
        prev_stream = bus.stream;
        prev_last   = bus.stream_last;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int             acc, nvalid, cacc;
    logic           rdy, gap, idxok;
    logic [WW-1:0]  wins[3];
    logic [MW-1:0]  metas[3];
    logic [WW-1:0]  w1;
    logic [VWW-1:0] vw;
    int             pat[6];

    pat = '{1, 0, 0, 1, 0, 1};
    bus.window_valid  = 1'b0;
    bus.window        = '0;
    bus.metadata      = '0;
    bus.stream_ready  = 1'b0;
    vbus.window_valid = 1'b0;
    vbus.window       = '0;
    vbus.metadata     = '0;
    vbus.stream_ready = 1'b0;

    // Reset values.
    #1 rst = 1'b1;
    #1;
    check("rst_stream_valid", BW'(bus.stream_valid), BW'(0));
    check("rst_stream", bus.stream, '0);
    check("rst_stream_last", BW'(bus.stream_last), BW'(0));
    check("rst_window_ready", BW'(bus.window_ready), BW'(1));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single window, continuous ready.
    w1 = mk_win(3, 0);
    bus.stream_ready = 1'b1;
    present(w1, 4'hA);
    @(posedge clk); #1;
    bus.window_valid = 1'b0;
    check("t1_latency_valid", BW'(bus.stream_valid), BW'(1));
    nvalid = 0;
    idxok  = 1'b1;
    for (int k = 0; k < NB; k++) begin
      if (bus.stream_valid) nvalid++;
      if (bus.stream[123:120] != k[IW-1:0]) idxok = 1'b0;
      if (bus.stream[127:124] != 4'hA) idxok = 1'b0;
      if (k == NB - 1) begin
        check("t1_b9_pad", BW'(bus.stream[119:72]), BW'(0));
        check("t1_b9_payload", BW'(bus.stream[71:0]), BW'(w1[1151:1080]));
        check("t1_b9_last", BW'(bus.stream_last), BW'(1));
      end else if (bus.stream_last) begin
        idxok = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("t1_consecutive_beats", BW'(nvalid), BW'(NB));
    check("t1_idx_meta_last", BW'(idxok), BW'(1));
    check("t1_idle_after", BW'(bus.stream_valid), BW'(0));

    // Backpressure pattern.
    bus.stream_ready = 1'b0;
    present(mk_win(7, 2), 4'h5);
    @(posedge clk); #1;
    bus.window_valid = 1'b0;
    for (int j = 0; j < 100 && exp_q.size() != 0; j++) begin
      bus.stream_ready = pat[j % 6][0];
      @(posedge clk); #1;
    end
    check("t2_drained", BW'(exp_q.size()), BW'(0));
    check("t2_idle_after", BW'(bus.stream_valid), BW'(0));

    // Continuous back-to-back windows.
    wins[0] = mk_win(11, 1); metas[0] = 4'h1;
    wins[1] = mk_win(13, 4); metas[1] = 4'h2;
    wins[2] = mk_win(17, 9); metas[2] = 4'h3;
    bus.stream_ready = 1'b1;
    present(wins[0], metas[0]);
    acc = 0; nvalid = 0; gap = 1'b0;
    for (int c = 0; c < 45; c++) begin
      rdy = bus.window_ready;
      @(posedge clk); #1;
      if (rdy && bus.window_valid) begin
        acc++;
        if (acc < 3) present(wins[acc], metas[acc]);
        else bus.window_valid = 1'b0;
      end
      if (bus.stream_valid) nvalid++;
      else if (nvalid > 0 && nvalid < 3 * NB) gap = 1'b1;
    end
    check("t3_beat_cycles", BW'(nvalid), BW'(3 * NB));
    check("t3_no_gap", BW'(gap), BW'(0));
    check("t3_accepted", BW'(acc), BW'(3));

    // Buffer full: third window must wait for the first to retire.
    wins[0] = mk_win(19, 3); metas[0] = 4'h4;
    wins[1] = mk_win(23, 5); metas[1] = 4'h7;
    wins[2] = mk_win(29, 6); metas[2] = 4'h9;
    bus.stream_ready = 1'b0;
    present(wins[0], metas[0]);
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      rdy = bus.window_ready;
      @(posedge clk); #1;
      if (rdy && bus.window_valid) begin
        acc++;
        if (acc < 3) present(wins[acc], metas[acc]);
        else bus.window_valid = 1'b0;
      end
    end
    check("t4_two_accepted", BW'(acc), BW'(2));
    check("t4_window_ready_low", BW'(bus.window_ready), BW'(0));
    check("t4_beat0_held", BW'(bus.stream), BW'(exp_beat(wins[0], metas[0], 0)));
    bus.stream_ready = 1'b1;
    cacc = 0;
    for (int c = 1; c <= 80; c++) begin
      rdy = bus.window_ready;
      @(posedge clk); #1;
      if (rdy && bus.window_valid) begin
        acc++;
        if (acc == 3) cacc = c;
        bus.window_valid = 1'b0;
      end
      if (acc == 3 && exp_q.size() == 0) break;
    end
    check("t4_c_accept_cycle", BW'(cacc), BW'(NB + 1));
    check("t4_drained", BW'(exp_q.size()), BW'(0));

    // Reset mid-window with a pending window.
    bus.stream_ready = 1'b0;
    present(mk_win(31, 7), 4'hB);
    @(posedge clk); #1;
    present(mk_win(37, 8), 4'hC);
    @(posedge clk); #1;
    bus.window_valid = 1'b0;
    bus.stream_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.stream_ready = 1'b0;
    check("t5_at_beat4", BW'(bus.stream[123:120]), BW'(4));
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("t5_rst_valid", BW'(bus.stream_valid), BW'(0));
    check("t5_rst_stream", bus.stream, '0);
    check("t5_rst_window_ready", BW'(bus.window_ready), BW'(1));
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.stream_ready = 1'b1;
    present(mk_win(41, 2), 4'hD);
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      rdy = bus.window_ready;
      @(posedge clk); #1;
      if (rdy && bus.window_valid) begin
        acc++;
        bus.window_valid = 1'b0;
      end
      if (acc == 1 && exp_q.size() == 0) break;
    end
    check("t5_d_drained", BW'(exp_q.size()), BW'(0));
    @(posedge clk); #1;
    check("t5_idle_after", BW'(bus.stream_valid), BW'(0));

    // Variant configuration: DATA_W = 57, five beats.
    for (int i = 0; i < int'(VWW); i++) vw[i] = ((i * 5 + 3) % 11 < 4);
    vbus.stream_ready = 1'b1;
    vbus.window_valid = 1'b1;
    vbus.window       = vw;
    vbus.metadata     = 4'h6;
    @(posedge clk); #1;
    vbus.window_valid = 1'b0;
    for (int k = 0; k < VNB; k++) begin
      check("v_beat", BW'(vbus.stream), BW'(vexp_beat(vw, 4'h6, k)));
      check("v_valid_last", BW'({vbus.stream_valid, vbus.stream_last}),
            BW'({1'b1, k == VNB - 1}));
      if (k == VNB - 1) begin
        check("v_b4_payload", BW'(vbus.stream[27:0]), BW'(vw[255:228]));
        check("v_b4_pad", BW'(vbus.stream[56:28]), BW'(0));
      end
      @(posedge clk); #1;
    end
    check("v_idle_after", BW'(vbus.stream_valid), BW'(0));

    check("final_queue_empty", BW'(exp_q.size()), BW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
